// File: rtl/irq_priority_ctrl_if.sv
// CPU-side interrupt handshake bundle: raw requests, enable, ack/eret in; request, vector, status out.
interface irq_priority_ctrl_if;
    localparam int unsigned NSRC = 3;
    localparam int unsigned VW   = 32;

    logic [NSRC-1:0] irq_in;
    logic            ie;
    logic            int_ack;
    logic            eret;
    logic            int_req;
    logic [VW-1:0]   int_vec;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] in_service;

    // Environment / CPU side
    modport master (
        output irq_in, ie, int_ack, eret,
        input  int_req, int_vec, pending, in_service
    );

    // Controller side
    modport slave (
        input  irq_in, ie, int_ack, eret,
        output int_req, int_vec, pending, in_service
    );
endinterface

// File: rtl/irq_priority_ctrl.sv
// Three-source fixed-priority nesting interrupt controller with synchronised edge-detected inputs.
module irq_priority_ctrl #(
    parameter logic [31:0] VEC0 = 32'h0000_0200,
    parameter logic [31:0] VEC1 = 32'h0000_0300,
    parameter logic [31:0] VEC2 = 32'h0000_0400
) (
    input logic                clk,
    input logic                rst,
    irq_priority_ctrl_if.slave bus
);
    localparam int unsigned NSRC = 3;
    localparam int unsigned SELW = 2;
    localparam int unsigned VW   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t          state_q;
    logic [NSRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] in_service_q, in_service_d;
    logic [SELW-1:0] sel_q;
    logic [VW-1:0]   int_vec_q;
    logic            int_req_q;

    logic [NSRC-1:0] rise_c;
    logic [NSRC-1:0] elig_c;
    logic [NSRC-1:0] is_clr_c;
    logic [NSRC-1:0] sel_oh_c;
    logic [SELW-1:0] sel_c;
    logic [VW-1:0]   vec_c;
    logic            ack_hit_c;

    // Eligibility against the current service level, arbitration, and pending/in-service next state
    always_comb begin
        rise_c    = sync2_q & ~prev_q;
        elig_c    = pending_q;
        is_clr_c  = in_service_q;
        if (in_service_q[2]) begin
            elig_c   = '0;
            is_clr_c = in_service_q & 3'b011;
        end else if (in_service_q[1]) begin
            elig_c   = pending_q & 3'b100;
            is_clr_c = in_service_q & 3'b101;
        end else if (in_service_q[0]) begin
            elig_c   = pending_q & 3'b110;
            is_clr_c = in_service_q & 3'b110;
        end

        if (elig_c[2])      sel_c = 2'd2;
        else if (elig_c[1]) sel_c = 2'd1;
        else                sel_c = 2'd0;

        case (sel_c)
            2'd2:    vec_c = VEC2;
            2'd1:    vec_c = VEC1;
            default: vec_c = VEC0;
        endcase

        ack_hit_c = (state_q == REQ) && bus.int_ack;
        sel_oh_c  = 3'b001 << sel_q;

        // Clear on accept first so a same-cycle rise re-pends the source
        pending_d = pending_q;
        if (ack_hit_c) pending_d = pending_d & ~sel_oh_c;
        pending_d = pending_d | rise_c;

        // eret retires the innermost level before a same-cycle accept nests the new one
        in_service_d = bus.eret ? is_clr_c : in_service_q;
        if (ack_hit_c) in_service_d = in_service_d | sel_oh_c;
    end

    // Synchroniser, request state and request/ack FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            sel_q        <= '0;
            int_vec_q    <= '0;
            int_req_q    <= 1'b0;
        end else begin
            sync1_q      <= bus.irq_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            case (state_q)
                IDLE: begin
                    if (bus.ie && (|elig_c)) begin
                        sel_q     <= sel_c;
                        int_vec_q <= vec_c;
                        int_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.int_ack || !bus.ie) begin
                        int_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    int_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_vec    = int_vec_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
endmodule
